// File: rtl/multibank_pingpong_buf.sv
// Multi-bank block buffer: the writer fills banks in rotation and the reader drains them in the same order.
// Optional build macro PPBUF_FLUSH_EN adds a flush input that commits a partially filled bank.
module multibank_pingpong_buf #(
    parameter int DATA_W    = 24,
    parameter int BLOCK_LEN = 80,
    parameter int NUM_BANKS = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_W-1:0]                  rx_data,
    input  logic                               rx_valid,
    output logic                               rx_ready,
`ifdef PPBUF_FLUSH_EN
    input  logic                               flush,
`endif
    output logic [DATA_W-1:0]                  tx_data,
    output logic                               tx_valid,
    input  logic                               tx_ready,
    output logic                               tx_last,
    output logic [$clog2(NUM_BANKS+1)-1:0]     full_banks
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W  = $clog2(BLOCK_LEN);
    localparam int LEN_W  = $clog2(BLOCK_LEN + 1);
    localparam int FB_W   = $clog2(NUM_BANKS + 1);

    typedef enum logic [1:0] {
        B_EMPTY    = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } bank_state_t;

    logic [DATA_W-1:0] mem_r [NUM_BANKS][BLOCK_LEN];
    bank_state_t       state_r [NUM_BANKS];
    bank_state_t       state_s [NUM_BANKS];
    logic [LEN_W-1:0]  len_r [NUM_BANKS];

    logic [BANK_W-1:0] wr_bank_r, wr_bank_s, rd_bank_r, rd_bank_s;
    logic [CNT_W-1:0]  wr_cnt_r, wr_cnt_s, rd_idx_r, rd_idx_s;
    logic [DATA_W-1:0] tx_data_r, tx_data_s;
    logic              tx_valid_r, tx_valid_s, tx_last_r, tx_last_s;
    logic              rx_ready_r, rx_ready_s;
    logic [FB_W-1:0]   full_banks_r, full_banks_s;

    logic              wr_accept_s, wr_last_s, flush_commit_s, commit_s;
    logic [LEN_W-1:0]  commit_len_s;
    logic              tx_fire_s, tx_load_s;

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        if (b == BANK_W'(NUM_BANKS - 1)) begin
            next_bank = BANK_W'(0);
        end else begin
            next_bank = b + BANK_W'(1);
        end
    endfunction

    // Next-state for bank states, pointers, output stage and occupancy count.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            state_s[b] = state_r[b];
        end
        wr_bank_s    = wr_bank_r;
        wr_cnt_s     = wr_cnt_r;
        rd_bank_s    = rd_bank_r;
        rd_idx_s     = rd_idx_r;
        tx_data_s    = tx_data_r;
        tx_valid_s   = tx_valid_r;
        tx_last_s    = tx_last_r;
        full_banks_s = FB_W'(0);

        wr_accept_s = rx_valid && rx_ready_r;
        wr_last_s   = wr_accept_s && (wr_cnt_r == CNT_W'(BLOCK_LEN - 1));
`ifdef PPBUF_FLUSH_EN
        flush_commit_s = flush && (state_r[wr_bank_r] == B_FILLING);
`else
        flush_commit_s = 1'b0;
`endif
        commit_s     = wr_last_s || flush_commit_s;
        // Length counts the word accepted in the commit cycle, so a full block yields BLOCK_LEN.
        commit_len_s = LEN_W'(wr_cnt_r) + LEN_W'(wr_accept_s);

        if (commit_s) begin
            state_s[wr_bank_r] = B_FULL;
            wr_cnt_s           = CNT_W'(0);
            wr_bank_s          = next_bank(wr_bank_r);
        end else if (wr_accept_s) begin
            state_s[wr_bank_r] = B_FILLING;
            wr_cnt_s           = wr_cnt_r + CNT_W'(1);
        end else begin
            wr_cnt_s = wr_cnt_r;
        end

        tx_fire_s = tx_valid_r && tx_ready;
        tx_load_s = !tx_valid_r || tx_ready;

        if (tx_fire_s && tx_last_r) begin
            state_s[rd_bank_r] = B_EMPTY;
            rd_bank_s          = next_bank(rd_bank_r);
        end else begin
            rd_bank_s = rd_bank_r;
        end

        // The next bank is picked up on the same edge the last word leaves, so there is no bubble.
        if (tx_fire_s && !tx_last_r) begin
            rd_idx_s  = rd_idx_r + CNT_W'(1);
            tx_data_s = mem_r[rd_bank_r][rd_idx_s];
            tx_last_s = (LEN_W'(rd_idx_s) == (len_r[rd_bank_r] - LEN_W'(1)));
        end else if (tx_load_s && (state_r[rd_bank_s] == B_FULL)) begin
            rd_idx_s           = CNT_W'(0);
            tx_data_s          = mem_r[rd_bank_s][CNT_W'(0)];
            tx_valid_s         = 1'b1;
            tx_last_s          = (len_r[rd_bank_s] == LEN_W'(1));
            state_s[rd_bank_s] = B_DRAINING;
        end else if (tx_load_s) begin
            tx_valid_s = 1'b0;
            tx_last_s  = 1'b0;
        end else begin
            tx_valid_s = tx_valid_r;
        end

        for (int b = 0; b < NUM_BANKS; b++) begin
            if ((state_s[b] == B_FULL) || (state_s[b] == B_DRAINING)) begin
                full_banks_s = full_banks_s + FB_W'(1);
            end else begin
                full_banks_s = full_banks_s;
            end
        end

        rx_ready_s = (state_s[wr_bank_s] == B_EMPTY) || (state_s[wr_bank_s] == B_FILLING);
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_r[b] <= B_EMPTY;
                len_r[b]   <= LEN_W'(0);
            end
            wr_bank_r    <= BANK_W'(0);
            rd_bank_r    <= BANK_W'(0);
            wr_cnt_r     <= CNT_W'(0);
            rd_idx_r     <= CNT_W'(0);
            tx_data_r    <= DATA_W'(0);
            tx_valid_r   <= 1'b0;
            tx_last_r    <= 1'b0;
            rx_ready_r   <= 1'b0;
            full_banks_r <= FB_W'(0);
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_r[b] <= state_s[b];
            end
            if (commit_s) begin
                len_r[wr_bank_r] <= commit_len_s;
            end
            wr_bank_r    <= wr_bank_s;
            rd_bank_r    <= rd_bank_s;
            wr_cnt_r     <= wr_cnt_s;
            rd_idx_r     <= rd_idx_s;
            tx_data_r    <= tx_data_s;
            tx_valid_r   <= tx_valid_s;
            tx_last_r    <= tx_last_s;
            rx_ready_r   <= rx_ready_s;
            full_banks_r <= full_banks_s;
        end
    end

    // Word storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_accept_s && !rst) begin
            mem_r[wr_bank_r][wr_cnt_r] <= rx_data;
        end
    end

    assign rx_ready   = rx_ready_r;
    assign tx_data    = tx_data_r;
    assign tx_valid   = tx_valid_r;
    assign tx_last    = tx_last_r;
    assign full_banks = full_banks_r;

endmodule

// File: tb/tb_multibank_pingpong_buf.sv
// Directed bench for multibank_pingpong_buf: a 2-bank instance and a 3-bank instance.
module tb_multibank_pingpong_buf;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_rx_valid, a_rx_ready, a_tx_valid, a_tx_ready, a_tx_last;
    logic [23:0] a_rx_data, a_tx_data;
    logic [1:0]  a_full_banks;
    logic        b_rst, b_rx_valid, b_rx_ready, b_tx_valid, b_tx_ready, b_tx_last;
    logic [23:0] b_rx_data, b_tx_data;
    logic [1:0]  b_full_banks;
`ifdef PPBUF_FLUSH_EN
    logic        a_flush, b_flush;
`endif

    int          errors = 0;
    int          checks = 0;
    int          sent, rcvd, cyc;
    logic [23:0] sb_q [$];
    logic [23:0] exp_word, data_prev;
    logic        stall_prev, last_prev;

    multibank_pingpong_buf #(.DATA_W(24), .BLOCK_LEN(80), .NUM_BANKS(2)) dut_a (
        .clk(clk), .rst(a_rst), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
`ifdef PPBUF_FLUSH_EN
        .flush(a_flush),
`endif
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_last(a_tx_last),
        .full_banks(a_full_banks)
    );

    multibank_pingpong_buf #(.DATA_W(24), .BLOCK_LEN(80), .NUM_BANKS(3)) dut_b (
        .clk(clk), .rst(b_rst), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
`ifdef PPBUF_FLUSH_EN
        .flush(b_flush),
`endif
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_last(b_tx_last),
        .full_banks(b_full_banks)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_reset_check(input string tag);
        chk({tag, "_tx_valid"}, a_tx_valid, 0);
        chk({tag, "_tx_last"}, a_tx_last, 0);
        chk({tag, "_tx_data"}, a_tx_data, 0);
        chk({tag, "_full_banks"}, a_full_banks, 0);
        chk({tag, "_rx_ready"}, a_rx_ready, 0);
    endtask

    // Back-to-back 80-word block, then drain with tx_ready held high.
    task automatic a_write_and_drain(input logic [23:0] base);
        a_tx_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            a_rx_data  = base + 24'(i);
            a_rx_valid = 1'b1;
            @(negedge clk);
        end
        a_rx_valid = 1'b0;
        chk("a_commit_tx_valid", a_tx_valid, 0);
        chk("a_commit_full_banks", a_full_banks, 1);
        @(negedge clk);
        for (int j = 0; j < 80; j++) begin
            chk("a_drain_valid", a_tx_valid, 1);
            chk("a_drain_data", a_tx_data, base + 24'(j));
            chk("a_drain_last", a_tx_last, 32'(j == 79));
            @(negedge clk);
        end
        chk("a_drain_done_valid", a_tx_valid, 0);
        chk("a_drain_done_full", a_full_banks, 0);
    endtask

    initial begin
        a_rst = 1'b1; a_rx_valid = 1'b0; a_rx_data = 24'h0; a_tx_ready = 1'b0;
        b_rst = 1'b1; b_rx_valid = 1'b0; b_rx_data = 24'h0; b_tx_ready = 1'b0;
`ifdef PPBUF_FLUSH_EN
        a_flush = 1'b0; b_flush = 1'b0;
`endif
        repeat (3) @(negedge clk);
        a_reset_check("a_rst");
        chk("b_rst_rx_ready", b_rx_ready, 0);
        chk("b_rst_tx_valid", b_tx_valid, 0);
        chk("b_rst_full_banks", b_full_banks, 0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        chk("a_rx_ready_after_rst", a_rx_ready, 1);
        chk("b_rx_ready_after_rst", b_rx_ready, 1);

        // Single block through the default 2-bank instance.
        a_write_and_drain(24'h100000);

        // One buffered block plus 40 words, then reset mid-block.
        a_tx_ready = 1'b0;
        for (int i = 0; i < 120; i++) begin
            a_rx_data  = 24'h200000 + 24'(i);
            a_rx_valid = 1'b1;
            @(negedge clk);
        end
        a_rx_valid = 1'b0;
        chk("a_pre_rst_full", a_full_banks, 1);
        chk("a_pre_rst_valid", a_tx_valid, 1);
        chk("a_pre_rst_data", a_tx_data, 24'h200000);
        a_rst = 1'b1;
        @(negedge clk);
        a_reset_check("a_mid_rst");
        a_rst = 1'b0;
        @(negedge clk);
        chk("a_rx_ready_after_mid_rst", a_rx_ready, 1);
        chk("a_tx_valid_after_mid_rst", a_tx_valid, 0);
        a_write_and_drain(24'h300000);

`ifdef PPBUF_FLUSH_EN
        // Partial block committed by flush.
        a_tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            a_rx_data  = 24'h400000 + 24'(i);
            a_rx_valid = 1'b1;
            @(negedge clk);
        end
        a_rx_valid = 1'b0;
        a_flush    = 1'b1;
        @(negedge clk);
        a_flush = 1'b0;
        chk("a_flush_full", a_full_banks, 1);
        chk("a_flush_valid_early", a_tx_valid, 0);
        @(negedge clk);
        a_tx_ready = 1'b1;
        for (int j = 0; j < 17; j++) begin
            chk("a_flush_valid", a_tx_valid, 1);
            chk("a_flush_data", a_tx_data, 24'h400000 + 24'(j));
            chk("a_flush_last", a_tx_last, 32'(j == 16));
            @(negedge clk);
        end
        chk("a_flush_done_valid", a_tx_valid, 0);
        chk("a_flush_done_full", a_full_banks, 0);
        a_flush = 1'b1;
        @(negedge clk);
        a_flush = 1'b0;
        chk("a_flush_empty_full", a_full_banks, 0);
        @(negedge clk);
        chk("a_flush_empty_valid", a_tx_valid, 0);
        chk("a_flush_empty_rx_ready", a_rx_ready, 1);
`endif

        // 3-bank instance: fill everything with the reader stalled.
        b_tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            chk("b_fill_rx_ready", b_rx_ready, 32'(i < 240));
            b_rx_data  = 24'h500000 + 24'(i);
            b_rx_valid = 1'b1;
            @(negedge clk);
        end
        b_rx_valid = 1'b0;
        chk("b_full3", b_full_banks, 3);
        chk("b_stall_valid", b_tx_valid, 1);
        chk("b_stall_data", b_tx_data, 24'h500000);
        chk("b_stall_rx_ready", b_rx_ready, 0);
        b_tx_ready = 1'b1;
        for (int j = 0; j < 240; j++) begin
            chk("b_drain_valid", b_tx_valid, 1);
            chk("b_drain_data", b_tx_data, 24'h500000 + 24'(j));
            chk("b_drain_last", b_tx_last, 32'((j % 80) == 79));
            chk("b_drain_rx_ready", b_rx_ready, 32'(j >= 80));
            chk("b_drain_full", b_full_banks, (j < 80) ? 3 : ((j < 160) ? 2 : 1));
            @(negedge clk);
        end
        chk("b_drain_done_valid", b_tx_valid, 0);
        chk("b_drain_done_full", b_full_banks, 0);
        chk("b_drain_done_rx_ready", b_rx_ready, 1);

        // Ten blocks with random reader stalls, checked against a scoreboard queue.
        sent = 0; rcvd = 0; cyc = 0; stall_prev = 1'b0;
        data_prev = 24'h0; last_prev = 1'b0;
        while ((rcvd < 800) && (cyc < 6000)) begin
            if (stall_prev) begin
                chk("b_hold_valid", b_tx_valid, 1);
                chk("b_hold_data", b_tx_data, data_prev);
                chk("b_hold_last", b_tx_last, last_prev);
            end
            b_tx_ready = ($urandom_range(0, 3) != 0);
            if (sent < 800) begin
                b_rx_valid = 1'b1;
                b_rx_data  = 24'h600000 + 24'(sent);
            end else begin
                b_rx_valid = 1'b0;
            end
            if (b_rx_valid && b_rx_ready) begin
                sb_q.push_back(b_rx_data);
                sent++;
            end
            if (b_tx_valid && b_tx_ready) begin
                if (sb_q.size() == 0) begin
                    chk("b_rand_spurious_word", b_tx_data, 24'hFFFFFF ^ b_tx_data);
                end else begin
                    exp_word = sb_q.pop_front();
                    chk("b_rand_data", b_tx_data, exp_word);
                    chk("b_rand_last", b_tx_last, 32'((rcvd % 80) == 79));
                    rcvd++;
                end
            end
            stall_prev = b_tx_valid && !b_tx_ready;
            data_prev  = b_tx_data;
            last_prev  = b_tx_last;
            @(negedge clk);
            cyc++;
        end
        b_rx_valid = 1'b0;
        b_tx_ready = 1'b0;
        chk("b_rand_received", rcvd, 800);
        chk("b_rand_sent", sent, 800);
        chk("b_rand_end_valid", b_tx_valid, 0);
        chk("b_rand_end_full", b_full_banks, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
